hardware_call_stack: RTL and testbench



---
 rtl/hardware_call_stack_pkg.sv | 16 +
 rtl/generic_register.sv | 20 ++
 rtl/hardware_call_stack.sv | 135 +++++++++++++
 tb/tb_hardware_call_stack.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hardware_call_stack_pkg.sv
// rtl/hardware_call_stack_pkg.sv - shared mode constants and pointer-width helper for the return-address stack
package hardware_call_stack_pkg;

    localparam int STACK_MODE_ENHANCED = 0;
    localparam int STACK_MODE_CLASSIC  = 1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/generic_register.sv
// rtl/generic_register.sv - enable-gated register with asynchronous clear to zero
module generic_register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hardware_call_stack.sv
// rtl/hardware_call_stack.sv - parametrised return-address stack, classic circular or enhanced saturating
module hardware_call_stack
    import hardware_call_stack_pkg::*;
#(
    parameter int  ADDR_WIDTH = 13,
    parameter int  DEPTH      = 8,
    parameter int  WRAP_MODE  = STACK_MODE_ENHANCED,
    parameter int  STVREN     = 1,
    localparam int PTR_W      = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_en,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic                  pop_en,
    output logic [ADDR_WIDTH-1:0] pop_addr,
    input  logic                  tos_wr_en,
    input  logic [ADDR_WIDTH-1:0] tos_wr_data,
    output logic [PTR_W:0]        stkptr,
    output logic                  stack_full,
    output logic                  stack_empty,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  flag_clr,
    output logic                  stack_reset_req
);

    localparam int CNT_W      = PTR_W + 1;
    localparam bit IS_CLASSIC = (WRAP_MODE == STACK_MODE_CLASSIC);
    localparam bit REQ_EN     = !IS_CLASSIC && (STVREN != 0);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      top_q, top_nxt;
    logic [CNT_W-1:0]      cnt_q, cnt_nxt;
    logic                  req_q;

    logic                  is_full, is_empty;
    logic                  do_replace, do_push, do_pop, do_tos;
    logic                  ovf_set, unf_set;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;
    logic [ADDR_WIDTH-1:0] wr_data;

    // Decode the request priority: push+pop replace, then push, pop, TOS write.
    always_comb begin
        is_full    = (cnt_q == CNT_W'(DEPTH));
        is_empty   = (cnt_q == '0);
        do_replace = push_en && pop_en && !is_empty;
        do_push    = push_en && !do_replace;
        do_pop     = pop_en && !push_en;
        do_tos     = tos_wr_en && !push_en && !pop_en && !is_empty;
        ovf_set    = do_push && is_full;
        unf_set    = do_pop && is_empty;
    end

    always_comb begin
        top_nxt = top_q;
        cnt_nxt = cnt_q;
        wr_en   = 1'b0;
        wr_idx  = top_q;
        wr_data = tos_wr_data;
        if (do_replace) begin
            wr_en   = 1'b1;
            wr_data = push_addr;
        end else if (do_push) begin
            // Classic mode keeps rotating when full, overwriting the oldest entry.
            if (!is_full || IS_CLASSIC) begin
                top_nxt = top_q + 1'b1;
                wr_en   = 1'b1;
                wr_idx  = top_nxt;
                wr_data = push_addr;
            end
            if (!is_full) begin
                cnt_nxt = cnt_q + 1'b1;
            end
        end else if (do_pop) begin
            if (!is_empty || IS_CLASSIC) begin
                top_nxt = top_q - 1'b1;
            end
            if (!is_empty) begin
                cnt_nxt = cnt_q - 1'b1;
            end
        end else if (do_tos) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= PTR_W'(DEPTH - 1);
            cnt_q <= '0;
            req_q <= 1'b0;
        end else begin
            top_q <= top_nxt;
            cnt_q <= cnt_nxt;
            req_q <= REQ_EN && (ovf_set || unf_set);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // A new error in the same cycle as flag_clr leaves the flag set.
    generic_register #(.WIDTH(1)) u_overflow (
        .clk (clk),
        .rst (rst),
        .en  (ovf_set || flag_clr),
        .d   (ovf_set),
        .q   (overflow)
    );

    generic_register #(.WIDTH(1)) u_underflow (
        .clk (clk),
        .rst (rst),
        .en  (unf_set || flag_clr),
        .d   (unf_set),
        .q   (underflow)
    );

    always_comb begin
        pop_addr        = (!IS_CLASSIC && is_empty) ? '0 : mem[top_q];
        stkptr          = cnt_q;
        stack_full      = is_full;
        stack_empty     = is_empty;
        stack_reset_req = req_q;
    end

endmodule

// File: tb/tb_hardware_call_stack.sv
// tb/tb_hardware_call_stack.sv - scoreboard bench running enhanced and classic stacks side by side
module tb_hardware_call_stack;

    localparam int AW = 13;
    localparam int D  = 8;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          push_en = 1'b0, pop_en = 1'b0, tos_wr_en = 1'b0, flag_clr = 1'b0;
    logic [AW-1:0] push_addr = '0, tos_wr_data = '0;

    logic [AW-1:0] de_pa, dc_pa;
    logic [PW:0]   de_sp, dc_sp;
    logic          de_full, de_empty, de_ovf, de_unf, de_req;
    logic          dc_full, dc_empty, dc_ovf, dc_unf, dc_req;

    hardware_call_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(0), .STVREN(1)) dut_enh (
        .clk(clk), .rst(rst), .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
        .pop_addr(de_pa), .tos_wr_en(tos_wr_en), .tos_wr_data(tos_wr_data), .stkptr(de_sp),
        .stack_full(de_full), .stack_empty(de_empty), .overflow(de_ovf), .underflow(de_unf),
        .flag_clr(flag_clr), .stack_reset_req(de_req)
    );

    hardware_call_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .WRAP_MODE(1), .STVREN(1)) dut_cls (
        .clk(clk), .rst(rst), .push_en(push_en), .push_addr(push_addr), .pop_en(pop_en),
        .pop_addr(dc_pa), .tos_wr_en(tos_wr_en), .tos_wr_data(tos_wr_data), .stkptr(dc_sp),
        .stack_full(dc_full), .stack_empty(dc_empty), .overflow(dc_ovf), .underflow(dc_unf),
        .flag_clr(flag_clr), .stack_reset_req(dc_req)
    );

    typedef struct packed {
        logic [AW-1:0] pa;
        logic [PW:0]   sp;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          unf;
        logic          req;
    } obs_t;

    typedef struct {
        obs_t  enh;
        obs_t  cls;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    string phase = "reset";

    // Enhanced reference: a bounded LIFO queue; classic reference: a ring with a wrapping top.
    logic [AW-1:0] es[$];
    bit            e_ovf, e_unf, e_req;
    logic [AW-1:0] ring[D];
    int            ctop, ccnt;
    bit            c_ovf, c_unf;

    function automatic obs_t enh_obs();
        obs_t o;
        int n = es.size();
        o.pa    = (n == 0) ? '0 : es[n-1];
        o.sp    = (PW+1)'(n);
        o.full  = (n == D);
        o.empty = (n == 0);
        o.ovf   = e_ovf;
        o.unf   = e_unf;
        o.req   = e_req;
        return o;
    endfunction

    function automatic obs_t cls_obs();
        obs_t o;
        o.pa    = ring[ctop];
        o.sp    = (PW+1)'(ccnt);
        o.full  = (ccnt == D);
        o.empty = (ccnt == 0);
        o.ovf   = c_ovf;
        o.unf   = c_unf;
        o.req   = 1'b0;
        return o;
    endfunction

    task automatic model_reset();
        es.delete();
        e_ovf = 0; e_unf = 0; e_req = 0;
        for (int i = 0; i < D; i++) ring[i] = '0;
        ctop = D - 1; ccnt = 0;
        c_ovf = 0; c_unf = 0;
    endtask

    task automatic model_step(input bit p, input logic [AW-1:0] pa, input bit po,
                              input bit tw, input logic [AW-1:0] td, input bit fc);
        bit eo = 0, eu = 0, co = 0, cu = 0;
        int n = es.size();
        if (p && po && n > 0) es[n-1] = pa;
        else if (p) begin
            if (n == D) eo = 1; else es.push_back(pa);
        end else if (po) begin
            if (n == 0) eu = 1; else void'(es.pop_back());
        end else if (tw && n > 0) es[n-1] = td;
        if (fc) begin e_ovf = 0; e_unf = 0; end
        if (eo) e_ovf = 1;
        if (eu) e_unf = 1;
        e_req = eo || eu;

        if (p && po && ccnt > 0) ring[ctop] = pa;
        else if (p) begin
            ctop = (ctop + 1) % D;
            ring[ctop] = pa;
            if (ccnt == D) co = 1; else ccnt++;
        end else if (po) begin
            ctop = (ctop + D - 1) % D;
            if (ccnt == 0) cu = 1; else ccnt--;
        end else if (tw && ccnt > 0) ring[ctop] = td;
        if (fc) begin c_ovf = 0; c_unf = 0; end
        if (co) c_ovf = 1;
        if (cu) c_unf = 1;
    endtask

    task automatic expect_now();
        exp_t x;
        x.enh = enh_obs();
        x.cls = cls_obs();
        x.tag = phase;
        sb.push_back(x);
    endtask

    task automatic step(input bit p, input logic [AW-1:0] pa, input bit po,
                        input bit tw, input logic [AW-1:0] td, input bit fc);
        @(negedge clk);
        push_en = p; push_addr = pa; pop_en = po;
        tos_wr_en = tw; tos_wr_data = td; flag_clr = fc;
        model_step(p, pa, po, tw, td, fc);
        expect_now();
    endtask

    task automatic push(input logic [AW-1:0] a); step(1, a, 0, 0, '0, 0); endtask
    task automatic pop();  step(0, '0, 1, 0, '0, 0); endtask
    task automatic idle(); step(0, '0, 0, 0, '0, 0); endtask

    // Reset lands between edges so the clear must be seen without a clock.
    task automatic async_reset();
        @(posedge clk);
        #2;
        push_en = 0; pop_en = 0; tos_wr_en = 0; flag_clr = 0;
        model_reset();
        expect_now();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check(input string who, input string tag, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s/%s @%0t: got pa=%h sp=%0d full=%b empty=%b ovf=%b unf=%b req=%b; expected pa=%h sp=%0d full=%b empty=%b ovf=%b unf=%b req=%b",
                     who, tag, $time, got.pa, got.sp, got.full, got.empty, got.ovf, got.unf, got.req,
                     exp.pa, exp.sp, exp.full, exp.empty, exp.ovf, exp.unf, exp.req);
        end
    endtask

    always begin : monitor
        exp_t x;
        obs_t ge, gc;
        @(posedge clk or posedge rst);
        #1;
        if (sb.size() > 0) begin
            x  = sb.pop_front();
            ge = {de_pa, de_sp, de_full, de_empty, de_ovf, de_unf, de_req};
            gc = {dc_pa, dc_sp, dc_full, dc_empty, dc_ovf, dc_unf, dc_req};
            check("enhanced", x.tag, ge, x.enh);
            check("classic", x.tag, gc, x.cls);
        end
    end

    initial begin
        bit p, po, tw, fc, pop_bias;
        model_reset();
        #2;
        expect_now();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        phase = "basic_lifo";
        push(13'h0123); push(13'h0456); push(13'h0789);
        pop(); pop(); pop(); idle();

        async_reset();
        phase = "overflow";
        for (int k = 1; k <= 9; k++) push(AW'(k));
        idle(); idle();
        for (int k = 0; k < 8; k++) pop();
        idle();

        async_reset();
        phase = "underflow";
        pop(); idle();
        step(0, '0, 0, 0, '0, 1);
        step(0, '0, 1, 0, '0, 1);
        idle();

        async_reset();
        phase = "replace_tos";
        push(13'h0AAA);
        step(1, 13'h0BBB, 1, 0, '0, 0);
        step(0, '0, 0, 1, 13'h0CCC, 0);
        step(1, 13'h0DDD, 0, 1, 13'h1111, 0);
        step(0, '0, 1, 1, 13'h1222, 0);
        idle();

        async_reset();
        phase = "empty_replace";
        step(1, 13'h0321, 1, 0, '0, 0);
        step(0, '0, 0, 1, 13'h0654, 0);
        idle();

        async_reset();
        phase = "reset_mid";
        for (int k = 0; k < 5; k++) push(AW'($urandom_range(1, 8191)));
        async_reset();

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            pop_bias = ((i / 40) % 2) == 1;
            p  = $urandom_range(0, 99) < (pop_bias ? 30 : 65);
            po = $urandom_range(0, 99) < (pop_bias ? 65 : 30);
            tw = $urandom_range(0, 9) == 0;
            fc = $urandom_range(0, 19) == 0;
            step(p, AW'($urandom), po, tw, AW'($urandom), fc);
            if (i % 150 == 149) async_reset();
        end
        idle();
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
